// File: rtl/iob_dbus_guard.sv
// Registered guard between the CPU data-bus port and the data interconnect.
// Retimes requests, bounds slave latency with a timeout, keeps sticky errors.
module iob_dbus_guard #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [ADDR_W+DATA_W+DATA_W/8:0]  m_req,
  output logic [DATA_W:0]                  m_resp,
  output logic [ADDR_W+DATA_W+DATA_W/8:0]  s_req,
  input  logic [DATA_W:0]                  s_resp,
  input  logic                             err_clr,
  output logic                             timeout_err,
  output logic [ADDR_W-1:0]                err_addr,
  output logic                             proto_err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              s_ready;
  logic [DATA_W-1:0] s_rdata;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              s_valid_q;
  logic              m_ready_q;
  logic [DATA_W-1:0] m_rdata_q;

  logic              tmo_err_q, tmo_err_d;
  logic              proto_err_q, proto_err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              tmo_set;
  logic              proto_set;

  assign m_valid = m_req[REQ_W-1];
  assign m_addr  = m_req[REQ_W-2 -: ADDR_W];
  assign m_wdata = m_req[STRB_W +: DATA_W];
  assign m_wstrb = m_req[STRB_W-1:0];
  assign s_ready = s_resp[0];
  assign s_rdata = s_resp[DATA_W:1];

  assign s_req       = {s_valid_q, addr_q, wdata_q, wstrb_q};
  assign m_resp      = {m_rdata_q, m_ready_q};
  assign timeout_err = tmo_err_q;
  assign err_addr    = err_addr_q;
  assign proto_err   = proto_err_q;

  // Transaction FSM: latch, issue for one cycle, then wait for ready or timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      s_valid_q <= 1'b0;
      m_ready_q <= 1'b0;
      m_rdata_q <= '0;
    end else begin
      s_valid_q <= 1'b0;
      m_ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (m_valid) begin
            addr_q    <= m_addr;
            wdata_q   <= m_wdata;
            wstrb_q   <= m_wstrb;
            s_valid_q <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (s_ready) begin
            m_rdata_q <= s_rdata;
            m_ready_q <= 1'b1;
            state_q   <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            m_rdata_q <= ERR_RDATA;
            m_ready_q <= 1'b1;
            state_q   <= IDLE;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky status next state: a set event beats a concurrent clear.
  always_comb begin
    tmo_set   = (state_q == WAIT) && !s_ready && (cnt_q == CNT_LAST);
    proto_set = (m_valid && (state_q != IDLE))
             || (s_ready && (state_q == IDLE));
    tmo_err_d   = tmo_set   | (tmo_err_q   & ~err_clr);
    proto_err_d = proto_set | (proto_err_q & ~err_clr);
    err_addr_d  = err_clr ? '0 : err_addr_q;
    if (tmo_set && (!tmo_err_q || err_clr)) begin
      err_addr_d = addr_q;
    end
  end

  // Sticky status registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      tmo_err_q   <= tmo_err_d;
      proto_err_q <= proto_err_d;
      err_addr_q  <= err_addr_d;
    end
  end

endmodule
